// File: rtl/fpu_pkg.sv
// Shared FPU types: fp16 word, comparator op codes, comparison flags,
// comparator FSM states and the canonical quiet-NaN builder.
package fpu_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    OP_CMP  = 2'd0,
    OP_MIN  = 2'd1,
    OP_MAX  = 2'd2,
    OP_RSVD = 2'd3
  } fp_op_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic unord;
  } comp_flags_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } comp_state_e;

  // Sign 0, exponent all-ones, mantissa MSB only; callers slice to their width.
  function automatic logic [127:0] canon_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fpu_comp_core.sv
// Combinational sign-magnitude comparator with MIN/MAX select.
// NaN-aware ordering is built only when FPU_COMP_NAN_EN is defined.
module fpu_comp_core
  import fpu_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  fp_op_e          op,
  output logic [FP_W-1:0] res,
  output comp_flags_t     flags
);

  logic            sign_a, sign_b;
  logic [FP_W-2:0] mag_a, mag_b;
  logic            mag_lt, both_zero;
  logic            nan_a, nan_b;

  assign sign_a    = a[FP_W-1];
  assign sign_b    = b[FP_W-1];
  assign mag_a     = a[FP_W-2:0];
  assign mag_b     = b[FP_W-2:0];
  assign mag_lt    = mag_a < mag_b;
  assign both_zero = (mag_a == '0) && (mag_b == '0);

`ifdef FPU_COMP_NAN_EN
  localparam logic [FP_W-1:0] QNAN = FP_W'(canon_qnan(EXP_W, MAN_W));
  assign nan_a = (&a[FP_W-2:MAN_W]) && (|a[MAN_W-1:0]);
  assign nan_b = (&b[FP_W-2:MAN_W]) && (|b[MAN_W-1:0]);
`else
  assign nan_a = 1'b0;
  assign nan_b = 1'b0;
`endif

  always_comb begin
    flags = '0;
    if (nan_a || nan_b) begin
      flags.unord = 1'b1;
    end else if (both_zero || (a == b)) begin
      flags.eq = 1'b1;
    end else if (sign_a != sign_b) begin
      flags.lt = sign_a;
      flags.gt = sign_b;
    end else if (!sign_a) begin
      flags.lt = mag_lt;
      flags.gt = !mag_lt;
    end else begin
      // Both negative: the larger magnitude is the smaller value.
      flags.lt = !mag_lt;
      flags.gt = mag_lt;
    end
  end

  always_comb begin
    res = a;
    case (op)
      OP_MIN:  res = flags.gt ? b : a;
      OP_MAX:  res = flags.lt ? b : a;
      default: res = a;
    endcase
`ifdef FPU_COMP_NAN_EN
    if (op == OP_MIN || op == OP_MAX) begin
      if (nan_a && nan_b) res = QNAN;
      else if (nan_a)     res = b;
      else if (nan_b)     res = a;
    end
`endif
  end

endmodule

// File: rtl/fpu_comp_stream.sv
// Handshaked FP comparator / min-max reducer, one result per packet.
// Optional NaN handling via FPU_COMP_NAN_EN (see fpu_comp_core).
module fpu_comp_stream
  import fpu_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 8,
  localparam int FP_W = 1 + EXP_W + MAN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [FP_W-1:0]  inA,
  input  logic [FP_W-1:0]  inB,
  input  logic [1:0]       inOp,
  input  logic             inReduce,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [FP_W-1:0]  outResult,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             unord,
  output logic [CNT_W-1:0] outCount,
  output logic             dbgState
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // inReady = !outValid || outReady, so a beat is only taken when the output
  // register is free or being drained in the same cycle; outValid is purely
  // registered and never combinational from inValid.

  comp_state_e      state, state_d;
  logic [FP_W-1:0]  acc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  fp_op_e           op_q;
  comp_flags_t      flags_q;

  logic [FP_W-1:0]  core_a, core_b, core_res;
  fp_op_e           core_op, in_op;
  comp_flags_t      core_flags;
  logic             accept, out_fire, start_reduce;

  assign in_op        = fp_op_e'(inOp);
  assign inReady      = !outValid || outReady;
  assign accept       = inValid && inReady;
  assign out_fire     = outValid && outReady;
  assign start_reduce = inReduce && !inLast && (in_op == OP_MIN || in_op == OP_MAX);
  assign cnt_inc      = (&cnt) ? cnt : cnt + 1'b1;

  assign core_a  = (state == ST_ACCUM) ? acc  : inA;
  assign core_b  = (state == ST_ACCUM) ? inA  : inB;
  assign core_op = (state == ST_ACCUM) ? op_q : in_op;

  fpu_comp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
    .a     (core_a),
    .b     (core_b),
    .op    (core_op),
    .res   (core_res),
    .flags (core_flags)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept && start_reduce) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && inLast)       state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= OP_CMP;
      outValid  <= 1'b0;
      outResult <= '0;
      flags_q   <= '0;
      outCount  <= '0;
    end else begin
      state <= state_d;
      if (out_fire) outValid <= 1'b0;
      if (accept) begin
        if (state == ST_IDLE) begin
          if (start_reduce) begin
            acc  <= core_res;
            cnt  <= CNT_W'(1);
            op_q <= in_op;
          end else begin
            outValid  <= 1'b1;
            outResult <= core_res;
            flags_q   <= core_flags;
            outCount  <= CNT_W'(1);
          end
        end else begin
          acc <= core_res;
          cnt <= cnt_inc;
          if (inLast) begin
            outValid  <= 1'b1;
            outResult <= core_res;
            flags_q   <= core_flags;
            outCount  <= cnt_inc;
          end
        end
      end
    end
  end

  assign lt       = flags_q.lt;
  assign eq       = flags_q.eq;
  assign gt       = flags_q.gt;
  assign unord    = flags_q.unord;
  assign dbgState = state;

endmodule

// File: tb/tb_fpu_comp_stream.sv
// Directed bench for fpu_comp_stream at fp16 defaults; NaN vectors follow
// whether FPU_COMP_NAN_EN is defined for the build.
module tb_fpu_comp_stream;

  localparam logic [1:0] CMP = 2'd0;
  localparam logic [1:0] MIN = 2'd1;
  localparam logic [1:0] MAX = 2'd2;

  // Flag nibble order: {lt, eq, gt, unord}
  localparam logic [3:0] F_LT = 4'b1000;
  localparam logic [3:0] F_EQ = 4'b0100;
  localparam logic [3:0] F_GT = 4'b0010;
  localparam logic [3:0] F_UN = 4'b0001;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, inReady;
  logic [15:0] inA, inB;
  logic [1:0]  inOp;
  logic        inReduce, inLast;
  logic        outValid, outReady;
  logic [15:0] outResult;
  logic        lt, eq, gt, unord;
  logic [7:0]  outCount;
  logic        dbgState;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_comp_stream dut (
    .clock     (clock),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .inA       (inA),
    .inB       (inB),
    .inOp      (inOp),
    .inReduce  (inReduce),
    .inLast    (inLast),
    .outValid  (outValid),
    .outReady  (outReady),
    .outResult (outResult),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .unord     (unord),
    .outCount  (outCount),
    .dbgState  (dbgState)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                      input logic red, input logic last);
    int waited;
    inA = a; inB = b; inOp = op; inReduce = red; inLast = last; inValid = 1'b1;
    waited = 0;
    while (!inReady && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!inReady) check("send_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    inValid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] res,
                           input logic [3:0] fl, input logic [7:0] cnt);
    check({tag, "_valid"}, 32'(outValid), 32'd1);
    check({tag, "_result"}, 32'(outResult), 32'(res));
    check({tag, "_flags"}, 32'({lt, eq, gt, unord}), 32'(fl));
    check({tag, "_count"}, 32'(outCount), 32'(cnt));
  endtask

  task automatic idle_cycle();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; inA = '0; inB = '0; inOp = CMP;
    inReduce = 1'b0; inLast = 1'b0; outReady = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_valid", 32'(outValid), 32'd0);
    check("rst_result", 32'(outResult), 32'd0);
    check("rst_flags", 32'({lt, eq, gt, unord}), 32'd0);
    check("rst_count", 32'(outCount), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);
    check("rst_inready", 32'(inReady), 32'd1);

    // Single-beat operations; result must be present one edge after accept.
    send(16'h3C00, 16'h3C00, CMP, 1'b0, 1'b0);
    check_out("cmp_eq", 16'h3C00, F_EQ, 8'd1);
    idle_cycle();
    check("drain_valid", 32'(outValid), 32'd0);
    send(16'hCB00, 16'h5770, MIN, 1'b0, 1'b0);
    check_out("min_neg", 16'hCB00, F_LT, 8'd1);
    send(16'hCB00, 16'h5770, MAX, 1'b0, 1'b0);
    check_out("max_neg", 16'h5770, F_LT, 8'd1);
    send(16'h0000, 16'h8000, CMP, 1'b0, 1'b0);
    check_out("cmp_zero", 16'h0000, F_EQ, 8'd1);
    send(16'h0000, 16'h8000, MIN, 1'b0, 1'b0);
    check_out("min_zero_tie", 16'h0000, F_EQ, 8'd1);
    send(16'hC000, 16'hBC00, MIN, 1'b0, 1'b0);
    check_out("min_both_neg", 16'hC000, F_LT, 8'd1);
    send(16'h7C00, 16'hFC00, MAX, 1'b0, 1'b0);
    check_out("max_inf", 16'h7C00, F_GT, 8'd1);
    send(16'h3C00, 16'h4000, 2'd3, 1'b0, 1'b0);
    check_out("rsvd_as_cmp", 16'h3C00, F_LT, 8'd1);
    send(16'h3C00, 16'h4000, MIN, 1'b1, 1'b1);
    check_out("reduce_single", 16'h3C00, F_LT, 8'd1);

`ifdef FPU_COMP_NAN_EN
    send(16'h7E00, 16'h3C00, MIN, 1'b0, 1'b0);
    check_out("nan_min", 16'h3C00, F_UN, 8'd1);
    send(16'h7E00, 16'h7C01, MIN, 1'b0, 1'b0);
    check_out("nan_both", 16'h7E00, F_UN, 8'd1);
`else
    send(16'h7E00, 16'h3C00, CMP, 1'b0, 1'b0);
    check_out("nan_plain_cmp", 16'h7E00, F_GT, 8'd1);
    send(16'h7E00, 16'h7C01, MIN, 1'b0, 1'b0);
    check_out("nan_plain_min", 16'h7C01, F_GT, 8'd1);
`endif

    // Three-beat MAX reduction: only the last beat produces an output.
    idle_cycle();
    send(16'h4B48, 16'h47D5, MAX, 1'b1, 1'b0);
    check("red_b1_valid", 32'(outValid), 32'd0);
    check("red_b1_state", 32'(dbgState), 32'd1);
    send(16'hCB00, 16'h1234, CMP, 1'b0, 1'b0);
    check("red_b2_valid", 32'(outValid), 32'd0);
    send(16'h3C00, 16'h7777, CMP, 1'b0, 1'b1);
    check_out("red_max", 16'h4B48, F_GT, 8'd3);
    check("red_end_state", 32'(dbgState), 32'd0);

    // Backpressure: output frozen and inReady low while outReady=0.
    idle_cycle();
    outReady = 1'b0;
    send(16'h4000, 16'h3C00, CMP, 1'b0, 1'b0);
    check_out("bp_first", 16'h4000, F_GT, 8'd1);
    inA = 16'h5000; inB = 16'h3C00; inOp = CMP; inReduce = 1'b0; inLast = 1'b0;
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(outValid), 32'd1);
      check("bp_hold_result", 32'(outResult), 32'h4000);
      check("bp_inready", 32'(inReady), 32'd0);
      idle_cycle();
    end
    outReady = 1'b1;
    #1;
    check("bp_release_inready", 32'(inReady), 32'd1);
    @(posedge clock); #1;
    inValid = 1'b0;
    check_out("bp_reload", 16'h5000, F_GT, 8'd1);
    idle_cycle();
    check("bp_drained", 32'(outValid), 32'd0);

    // Reset mid-packet must discard the partial MIN reduction.
    send(16'h1000, 16'h2000, MIN, 1'b1, 1'b0);
    send(16'h0400, 16'h0000, MIN, 1'b1, 1'b0);
    check("pre_rst_state", 32'(dbgState), 32'd1);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    check("mid_rst_state", 32'(dbgState), 32'd0);
    check("mid_rst_valid", 32'(outValid), 32'd0);
    send(16'h3C00, 16'h3800, MIN, 1'b1, 1'b0);
    check("post_rst_b1_valid", 32'(outValid), 32'd0);
    send(16'h3A00, 16'h0000, MIN, 1'b1, 1'b1);
    check_out("post_rst_min", 16'h3800, F_LT, 8'd2);

    // Long packet: beat counter saturates at 255.
    idle_cycle();
    send(16'h0001, 16'h0000, MAX, 1'b1, 1'b0);
    for (int i = 2; i < 300; i++) send(16'(i), 16'h0000, MAX, 1'b1, 1'b0);
    send(16'h0080, 16'h0000, MAX, 1'b1, 1'b1);
    check_out("sat_count", 16'd299, F_GT, 8'd255);

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
